// File: rtl/exc_redirect_ctrl_pkg.sv
// Shared encodings for the CP0 exception redirect controller: FSM states,
// event type and the default general-exception entry point.
package exc_redirect_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2,
      ST_DRAIN    = 2'd3
   } exc_state_e;

   typedef enum logic {
      EVT_EXC  = 1'b0,
      EVT_ERET = 1'b1
   } evt_type_e;

   localparam logic [31:0] EXC_VECTOR_DEF   = 32'hBFC0_0380;
   localparam int          DRAIN_CYCLES_DEF = 2;
   localparam int          CNT_W_DEF        = 16;

endpackage

// File: rtl/exc_redirect_ctrl_if.sv
// CP0-to-pipeline exception interface plus the fetch redirect handshake.
// The slave modport is the controller side; master is the CP0/fetch side.
interface exc_redirect_ctrl_if #(
   parameter int CNT_W = 16
) ();

   logic             cp0_intexp_1;
   logic             cp0_intexp_2;
   logic             cp0_cln_1;
   logic             cp0_cln_2;
   logic [31:0]      epc_i;
   logic             redirect_ready;
   logic             kill_lane2;
   logic             flush_o;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic             exc_busy;
   logic [CNT_W-1:0] exc_count;

   modport master (
      output cp0_intexp_1, cp0_intexp_2, cp0_cln_1, cp0_cln_2, epc_i, redirect_ready,
      input  kill_lane2, flush_o, redirect_valid, redirect_pc, exc_busy, exc_count
   );

   modport slave (
      input  cp0_intexp_1, cp0_intexp_2, cp0_cln_1, cp0_cln_2, epc_i, redirect_ready,
      output kill_lane2, flush_o, redirect_valid, redirect_pc, exc_busy, exc_count
   );

endinterface

// File: rtl/exc_redirect_ctrl_drain_timer.sv
// Post-redirect drain timer: down-counter loaded on DRAIN entry, done at terminal count zero.
module exc_redirect_ctrl_drain_timer #(
   parameter int DRAIN_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic done
);

   localparam int            W        = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
   // Loaded with N-1 so that DRAIN lasts exactly N cycles including the terminal one.
   localparam logic [W-1:0]  LOAD_VAL = W'((DRAIN_CYCLES < 1) ? 0 : DRAIN_CYCLES - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/exc_redirect_ctrl.sv
// Arbitrates the two CP0 exception lanes, flushes the pipeline and issues a
// handshaked PC redirect (exception vector or EPC), then drains before rearming.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | watching cln lanes; lane 1 wins, kill_lane2 follows cln_1
//   FLUSH    | one-cycle flush; ERET samples EPC here
//   REDIRECT | flush held, redirect_valid until fetch accepts
//   DRAIN    | DRAIN_CYCLES cycles ignoring CP0 while Status/EXL settles
module exc_redirect_ctrl
   import exc_redirect_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
   parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int          CNT_W        = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   exc_redirect_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   exc_state_e       state_q, state_d;
   evt_type_e        type_q, type_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic evt1, evt2, evt_any, evt_is_exc;
   logic flush, redirect_valid;
   logic drain_load, drain_en, drain_done;

   always_comb begin
      evt1       = bus.cp0_cln_1;
      evt2       = bus.cp0_cln_2 & ~bus.cp0_cln_1;
      evt_any    = evt1 | evt2;
      evt_is_exc = evt1 ? bus.cp0_intexp_1 : bus.cp0_intexp_2;
   end

   always_comb begin
      state_d        = state_q;
      type_d         = type_q;
      pc_d           = pc_q;
      cnt_d          = cnt_q;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      drain_load     = 1'b0;
      drain_en       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (evt_any) begin
               state_d = ST_FLUSH;
               type_d  = evt_is_exc ? EVT_EXC : EVT_ERET;
               if (evt_is_exc) begin
                  pc_d = EXC_VECTOR;
                  if (cnt_q != CNT_MAX) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
         end
         ST_FLUSH: begin
            flush   = 1'b1;
            state_d = ST_REDIRECT;
            // CP0 registers EPC_o, so it is only valid one cycle after the event.
            if (type_q == EVT_ERET) begin
               pc_d = bus.epc_i;
            end
         end
         ST_REDIRECT: begin
            flush          = 1'b1;
            redirect_valid = 1'b1;
            if (bus.redirect_ready) begin
               if (DRAIN_CYCLES == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d    = ST_DRAIN;
                  drain_load = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            drain_en = 1'b1;
            if (drain_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         type_q  <= EVT_EXC;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   exc_redirect_ctrl_drain_timer #(
      .DRAIN_CYCLES (DRAIN_CYCLES)
   ) u_drain_timer (
      .clk   (clk),
      .reset (reset),
      .load  (drain_load),
      .en    (drain_en),
      .done  (drain_done)
   );

   assign bus.kill_lane2     = (state_q == ST_IDLE) & bus.cp0_cln_1;
   assign bus.flush_o        = flush;
   assign bus.redirect_valid = redirect_valid;
   assign bus.redirect_pc    = pc_q;
   assign bus.exc_busy       = (state_q != ST_IDLE);
   assign bus.exc_count      = cnt_q;

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed bench for exc_redirect_ctrl: stimulus pushes expected redirects into a
// scoreboard queue, a negedge monitor pops and compares on each handshake.
module tb_exc_redirect_ctrl;
   import exc_redirect_ctrl_pkg::*;

   localparam logic [31:0] VEC = 32'hBFC0_0380;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cln_1, cln_2, intexp_1, intexp_2, ready;
   logic [31:0] epc;

   always #5 clk = ~clk;

   exc_redirect_ctrl_if #(.CNT_W(16)) bus ();
   exc_redirect_ctrl_if #(.CNT_W(2))  bus_s ();

   assign bus.cp0_cln_1        = cln_1;
   assign bus.cp0_cln_2        = cln_2;
   assign bus.cp0_intexp_1     = intexp_1;
   assign bus.cp0_intexp_2     = intexp_2;
   assign bus.epc_i            = epc;
   assign bus.redirect_ready   = ready;
   assign bus_s.cp0_cln_1      = cln_1;
   assign bus_s.cp0_cln_2      = cln_2;
   assign bus_s.cp0_intexp_1   = intexp_1;
   assign bus_s.cp0_intexp_2   = intexp_2;
   assign bus_s.epc_i          = epc;
   assign bus_s.redirect_ready = ready;

   exc_redirect_ctrl #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(2), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Narrow counter copy so saturation is reachable in a short run.
   exc_redirect_ctrl #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(2), .CNT_W(2)) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_s)
   );

   typedef struct {
      logic [31:0] pc;
      logic [15:0] cnt;
   } exp_t;

   typedef struct {
      logic        c1, i1, c2, i2;
      logic [31:0] epc;
      logic [31:0] exp_pc;
      logic        exp_kill;
      logic [15:0] exp_cnt;
      logic [1:0]  exp_sat;
   } vec_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   vec_t        vecs[5];
   vec_t        v;
   int          n_checks = 0;
   int          n_fail = 0;
   logic        prev_valid = 1'b0;
   logic [31:0] prev_pc = '0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (bus.redirect_valid && prev_valid)
            chk32("pc_stable", bus.redirect_pc, prev_pc);
         if (bus.redirect_valid && bus.redirect_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_redirect: got pc %h expected none", bus.redirect_pc);
            end else begin
               mon_e = exp_q.pop_front();
               chk32("redirect_pc", bus.redirect_pc, mon_e.pc);
               chk32("exc_count", 32'(bus.exc_count), 32'(mon_e.cnt));
            end
         end
      end
      prev_valid = bus.redirect_valid & reset;
      prev_pc    = bus.redirect_pc;
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Event cycle, FLUSH cycle and first REDIRECT cycle; returns just after the edge leaving REDIRECT cycle 1.
   task automatic fire(input vec_t fv);
      cln_1 = fv.c1; intexp_1 = fv.i1; cln_2 = fv.c2; intexp_2 = fv.i2;
      epc = 32'hDEAD_BEEF;
      exp_q.push_back('{fv.exp_pc, fv.exp_cnt});
      @(negedge clk);
      chk1("kill_lane2_evt", bus.kill_lane2, fv.exp_kill);
      chk1("flush_evt", bus.flush_o, 1'b0);
      next_cycle();
      cln_1 = 1'b0; intexp_1 = 1'b0; cln_2 = 1'b0; intexp_2 = 1'b0;
      epc = fv.epc;
      @(negedge clk);
      chk1("flush_in_flush", bus.flush_o, 1'b1);
      chk1("valid_in_flush", bus.redirect_valid, 1'b0);
      next_cycle();
      epc = 32'h5555_AAAA;
      @(negedge clk);
      chk1("valid_in_redirect", bus.redirect_valid, 1'b1);
      chk1("flush_in_redirect", bus.flush_o, 1'b1);
      next_cycle();
   endtask

   task automatic drain_check();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk1("valid_in_drain", bus.redirect_valid, 1'b0);
         chk1("flush_in_drain", bus.flush_o, 1'b0);
         chk1("busy_in_drain", bus.exc_busy, 1'b1);
         chk1("kill_in_drain", bus.kill_lane2, 1'b0);
         next_cycle();
      end
      @(negedge clk);
      chk1("busy_after_drain", bus.exc_busy, 1'b0);
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cln_1 = 1'b1; cln_2 = 1'b0; intexp_1 = 1'b0; intexp_2 = 1'b0;
      ready = 1'b1; epc = '0;

      // c1 i1 c2 i2 epc exp_pc kill cnt sat
      vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         VEC,           1'b1, 16'd1, 2'd1};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_1234, 32'h8000_1234, 1'b0, 16'd1, 2'd1};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_4000, 32'h8000_4000, 1'b1, 16'd1, 2'd1};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, VEC,           1'b0, 16'd2, 2'd2};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1234, VEC,           1'b1, 16'd3, 2'd3};

      #12;
      chk1("rst_kill_follows_eq", bus.kill_lane2, 1'b1);
      chk1("rst_flush", bus.flush_o, 1'b0);
      chk1("rst_valid", bus.redirect_valid, 1'b0);
      chk32("rst_pc", bus.redirect_pc, 32'h0);
      chk32("rst_count", 32'(bus.exc_count), 32'h0);
      chk1("rst_busy", bus.exc_busy, 1'b0);
      cln_1 = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      next_cycle();

      for (int i = 0; i < 5; i++) begin
         fire(vecs[i]);
         drain_check();
         chk32("sat_count", 32'(bus_s.exc_count), 32'(vecs[i].exp_sat));
      end

      intexp_1 = 1'b1; intexp_2 = 1'b1;
      @(negedge clk);
      chk1("intexp_only_kill", bus.kill_lane2, 1'b0);
      next_cycle();
      intexp_1 = 1'b0; intexp_2 = 1'b0;
      @(negedge clk);
      chk1("intexp_only_busy", bus.exc_busy, 1'b0);
      next_cycle();

      // Fetch stalls for three REDIRECT cycles, accepts on the fourth.
      ready = 1'b0;
      v = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, VEC, 1'b1, 16'd4, 2'd3};
      fire(v);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk1("valid_stalled", bus.redirect_valid, 1'b1);
         chk32("pc_stalled", bus.redirect_pc, VEC);
         next_cycle();
      end
      ready = 1'b1;
      @(negedge clk);
      chk1("valid_accept", bus.redirect_valid, 1'b1);
      next_cycle();
      drain_check();
      chk32("sat_hold", 32'(bus_s.exc_count), 32'd3);

      // cln_1 held through the whole sequence: one redirect, then a second from IDLE.
      cln_1 = 1'b1; intexp_1 = 1'b1;
      exp_q.push_back('{VEC, 16'd5});
      exp_q.push_back('{VEC, 16'd6});
      @(negedge clk);
      chk1("hold_kill_c0", bus.kill_lane2, 1'b1);
      next_cycle();
      @(negedge clk);
      chk1("hold_flush_c1", bus.flush_o, 1'b1);
      chk1("hold_kill_c1", bus.kill_lane2, 1'b0);
      next_cycle();
      @(negedge clk);
      chk1("hold_valid_c2", bus.redirect_valid, 1'b1);
      next_cycle();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk1("hold_drain_valid", bus.redirect_valid, 1'b0);
         chk1("hold_drain_kill", bus.kill_lane2, 1'b0);
         next_cycle();
      end
      @(negedge clk);
      chk1("hold_idle_busy", bus.exc_busy, 1'b0);
      chk1("hold_idle_kill", bus.kill_lane2, 1'b1);
      next_cycle();
      cln_1 = 1'b0; intexp_1 = 1'b0;
      @(negedge clk);
      chk1("hold2_flush", bus.flush_o, 1'b1);
      chk1("hold2_valid", bus.redirect_valid, 1'b0);
      next_cycle();
      @(negedge clk);
      chk1("hold2_valid_redir", bus.redirect_valid, 1'b1);
      next_cycle();
      drain_check();
      chk32("hold_queue_empty", 32'(exp_q.size()), 32'd0);
      chk32("sat_hold2", 32'(bus_s.exc_count), 32'd3);

      // Asynchronous reset in the middle of REDIRECT.
      ready = 1'b0;
      v = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, VEC, 1'b1, 16'd7, 2'd3};
      fire(v);
      #2;
      reset = 1'b0;
      #1;
      chk1("arst_flush", bus.flush_o, 1'b0);
      chk1("arst_valid", bus.redirect_valid, 1'b0);
      chk32("arst_pc", bus.redirect_pc, 32'h0);
      chk32("arst_count", 32'(bus.exc_count), 32'h0);
      chk1("arst_busy", bus.exc_busy, 1'b0);
      chk1("arst_kill", bus.kill_lane2, 1'b0);
      chk32("arst_sat_count", 32'(bus_s.exc_count), 32'h0);
      exp_q.delete();
      ready = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      next_cycle();

      v = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0, VEC, 1'b0, 16'd1, 2'd1};
      fire(v);
      drain_check();
      chk32("post_rst_sat", 32'(bus_s.exc_count), 32'd1);
      chk32("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
